// File: rtl/conv_tile_scheduler.sv
// rtl/conv_tile_scheduler.sv - raster-order tile scheduler driving a 4x4-output conv engine
// Optional busy-cycle counter output enabled by macro CONV_SCHED_PERF_EN.
module conv_tile_scheduler #(
    parameter int IDX_W    = 4,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [IDX_W-1:0] cmd_tiles_x,
    input  logic [IDX_W-1:0] cmd_tiles_y,
    output logic             load_req,
    input  logic             load_ack,
    output logic [IDX_W-1:0] tile_row,
    output logic [IDX_W-1:0] tile_col,
    output logic             conv_clr,
    output logic             conv_start,
    input  logic             conv_done,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [15:0]      perf_busy_cycles
`endif
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLR,
        START,
        WAIT,
        WB
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [IDX_W-1:0] last_row;
    logic [IDX_W-1:0] last_col;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             wb_fire;
    logic             last_tile;
    logic             accept;

    assign accept    = (state == IDLE) && cmd_valid;
    assign wb_fire   = (state == WB) && wb_ready;
    assign last_tile = (tile_row == last_row) && (tile_col == last_col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // wait_cnt == 0 marks the first WAIT cycle, where a stale conv_done is ignored
    always_comb begin
        state_n     = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:  if (cmd_valid) state_n = LOAD;
            LOAD:  if (load_ack) state_n = CLR;
            CLR:   state_n = START;
            START: state_n = WAIT;
            WAIT: begin
                if ((wait_cnt != '0) && conv_done) begin
                    state_n = WB;
                end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                    state_n     = WB;
                    timeout_hit = 1'b1;
                end
            end
            WB:    if (wb_ready) state_n = last_tile ? IDLE : LOAD;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready   <= 1'b1;
            load_req    <= 1'b0;
            conv_clr    <= 1'b0;
            conv_start  <= 1'b0;
            wb_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cmd_ready  <= (state_n == IDLE);
            load_req   <= (state_n == LOAD);
            conv_clr   <= (state_n == CLR);
            conv_start <= (state_n == START);
            wb_valid   <= (state_n == WB);
            busy       <= (state_n != IDLE);
            frame_done <= wb_fire && last_tile;
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == START) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A tile count of zero is treated as one, so the last index saturates at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_row <= '0;
            last_col <= '0;
            tile_row <= '0;
            tile_col <= '0;
        end else if (accept) begin
            last_row <= (cmd_tiles_y == '0) ? '0 : cmd_tiles_y - 1'b1;
            last_col <= (cmd_tiles_x == '0) ? '0 : cmd_tiles_x - 1'b1;
            tile_row <= '0;
            tile_col <= '0;
        end else if (wb_fire && !last_tile) begin
            if (tile_col == last_col) begin
                tile_col <= '0;
                tile_row <= tile_row + 1'b1;
            end else begin
                tile_col <= tile_col + 1'b1;
            end
        end
    end

`ifdef CONV_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_cycles <= '0;
        end else if (accept) begin
            perf_busy_cycles <= '0;
        end else if (busy && (perf_busy_cycles != 16'hFFFF)) begin
            perf_busy_cycles <= perf_busy_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// tb/tb_conv_tile_scheduler.sv - randomized self-checking bench for conv_tile_scheduler
module tb_conv_tile_scheduler;

    localparam int IDX_W    = 4;
    localparam int WAIT_MAX = 12;
    localparam int NEVER    = 1 << 30;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [IDX_W-1:0] cmd_tiles_x;
    logic [IDX_W-1:0] cmd_tiles_y;
    logic             load_req;
    logic             load_ack;
    logic [IDX_W-1:0] tile_row;
    logic [IDX_W-1:0] tile_col;
    logic             conv_clr;
    logic             conv_start;
    logic             conv_done;
    logic             wb_valid;
    logic             wb_ready;
    logic             busy;
    logic             frame_done;
    logic             timeout_err;
`ifdef CONV_SCHED_PERF_EN
    logic [15:0]      perf_busy_cycles;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic te_exp   = 1'b0;
    bit   aborted;

    conv_tile_scheduler #(.IDX_W(IDX_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_tiles_x (cmd_tiles_x),
        .cmd_tiles_y (cmd_tiles_y),
        .load_req    (load_req),
        .load_ack    (load_ack),
        .tile_row    (tile_row),
        .tile_col    (tile_col),
        .conv_clr    (conv_clr),
        .conv_start  (conv_start),
        .conv_done   (conv_done),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
`ifdef CONV_SCHED_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_load_req"}, load_req, 0);
        check({tag, "_conv_clr"}, conv_clr, 0);
        check({tag, "_conv_start"}, conv_start, 0);
        check({tag, "_wb_valid"}, wb_valid, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_tile_row"}, tile_row, 0);
        check({tag, "_tile_col"}, tile_col, 0);
`ifdef CONV_SCHED_PERF_EN
        check({tag, "_perf"}, perf_busy_cycles, 0);
`endif
    endtask

    // dmode: 0 = conv_done after a random delay, 1 = conv_done stuck high, 2 = conv_done stuck low
    task automatic run_frame(input int tx, input int ty, input int dmode, input bit wbhold,
                             input int abort_start);
        int   exp_r[$];
        int   exp_c[$];
        int   ex, ey, ntiles;
        int   ack_cyc, done_at, exp_wb, wb_start, nstart, last_hs, busy_cnt;
        int   s, k;
        bit   fired, finished;
        logic [IDX_W-1:0] held_r, held_c;

        ex = (tx == 0) ? 1 : tx;
        ey = (ty == 0) ? 1 : ty;
        ntiles = ex * ey;
        for (int r = 0; r < ey; r++)
            for (int c = 0; c < ex; c++) begin
                exp_r.push_back(r);
                exp_c.push_back(c);
            end
        ack_cyc = -100; done_at = NEVER; exp_wb = -1; wb_start = -1;
        nstart = 0; last_hs = -100; busy_cnt = 0; fired = 0; finished = 0;
        aborted = 0;

        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
        cmd_valid   = 1'b1;
        cmd_tiles_x = IDX_W'(tx);
        cmd_tiles_y = IDX_W'(ty);
        @(negedge clk);
        cmd_tiles_x = IDX_W'($urandom_range(0, 15));
        cmd_tiles_y = IDX_W'($urandom_range(0, 15));

        for (int n = 0; n < 4000; n++) begin
            if (busy) busy_cnt++;
            if (fired) begin
                check("wb_drop_after_handshake", wb_valid, 0);
                fired = 0;
            end
            if (conv_clr) done_at = NEVER;
            if (conv_start) begin
                nstart++;
                check("ack_to_start_latency", cyc - ack_cyc, 2);
                s = cyc;
                done_at = s + int'($urandom_range(1, 4));
                k = (dmode == 1) ? s : (dmode == 2) ? NEVER : done_at;
                if (k < s + 2) k = s + 2;
                if (k > s + WAIT_MAX) begin
                    k = s + WAIT_MAX;
                    te_exp = 1'b1;
                end
                exp_wb = k + 1;
                if (nstart == abort_start) begin
                    conv_done = 1'b0;
                    cmd_valid = 1'b0;
                    @(negedge clk);
                    aborted = 1;
                    break;
                end
            end
            if (wb_valid) begin
                if (wb_start < 0) begin
                    wb_start = cyc;
                    check("wb_entry_cycle", cyc, exp_wb);
                    check("wb_tile_row", tile_row, (exp_r.size() > 0) ? exp_r[0] : -1);
                    check("wb_tile_col", tile_col, (exp_c.size() > 0) ? exp_c[0] : -1);
                    held_r = tile_row;
                    held_c = tile_col;
                end else begin
                    check("wb_row_stable", tile_row, held_r);
                    check("wb_col_stable", tile_col, held_c);
                end
            end
            if (frame_done) begin
                check("frame_done_after_last_wb", cyc - last_hs, 1);
                check("tiles_remaining", exp_r.size(), 0);
                check("conv_start_count", nstart, ntiles);
                check("timeout_err_flag", timeout_err, te_exp);
                check("done_busy", busy, 0);
                check("done_cmd_ready", cmd_ready, 1);
`ifdef CONV_SCHED_PERF_EN
                check("perf_busy_cycles", perf_busy_cycles, busy_cnt);
`endif
                cmd_valid = 1'b0;
                finished = 1;
                break;
            end
            load_ack = 1'($urandom_range(0, 1));
            if (load_req && load_ack) ack_cyc = cyc;
            conv_done = (dmode == 1) ? 1'b1 : (dmode == 2) ? 1'b0 : (cyc >= done_at);
            if (wb_valid && wbhold) wb_ready = (cyc - wb_start >= 10);
            else wb_ready = 1'($urandom_range(0, 1));
            if (wb_valid && wb_ready) begin
                if (wbhold) check("wb_hold_cycles", cyc - wb_start, 10);
                void'(exp_r.pop_front());
                void'(exp_c.pop_front());
                wb_start = -1;
                last_hs = cyc;
                fired = 1;
            end
            cmd_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        checks++;
        assert (finished || aborted) else begin
            failures++;
            $error("FAIL frame_budget observed=unfinished expected=frame_done");
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_tiles_x = '0; cmd_tiles_y = '0;
        load_ack = 1'b0; conv_done = 1'b0; wb_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        run_frame(2, 2, 0, 0, 0);
        run_frame(0, 3, 0, 0, 0);
        run_frame(1, 1, 1, 0, 0);
        run_frame(2, 1, 1, 0, 0);
        run_frame(1, 1, 2, 0, 0);
        run_frame(2, 2, 0, 0, 0);
        run_frame(2, 1, 0, 1, 0);

        run_frame(2, 2, 0, 0, 2);
        check("abort_reached", aborted, 1);
        #2 rst = 1'b1;
        te_exp = 1'b0;
        #1 check_reset_values("midframe_reset");
        @(negedge clk);
        rst = 1'b0;

        run_frame(3, 2, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            run_frame(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_tile_scheduler.md
CONV_TILE_SCHEDULER -- requirements
Module: conv_tile_scheduler

Interface
REQ-001 The block SHALL have parameter IDX_W, default 4, giving the width of the tile row/column index.
REQ-002 The block SHALL have parameter WAIT_MAX, default 255, giving the maximum number of cycles to wait for conv_done.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  frame command offered.
REQ-006 cmd_ready  output  1  scheduler accepts a command.
REQ-007 cmd_tiles_x  input  IDX_W  number of 4x4 output tiles per row.
REQ-008 cmd_tiles_y  input  IDX_W  number of tile rows.
REQ-009 load_req  output  1  request to load the 6x6 input tile and 3x3 kernel.
REQ-010 load_ack  input  1  load complete.
REQ-011 tile_row  output  IDX_W  current tile row index.
REQ-012 tile_col  output  IDX_W  current tile column index.
REQ-013 conv_clr  output  1  one-cycle clear pulse to the convolution engine.
REQ-014 conv_start  output  1  one-cycle start pulse to the convolution engine.
REQ-015 conv_done  input  1  engine done level, sticky until the engine is cleared.
REQ-016 wb_valid  output  1  4x4 result ready for writeback at tile_row/tile_col.
REQ-017 wb_ready  input  1  writeback sink accepts.
REQ-018 busy  output  1  frame in progress.
REQ-019 frame_done  output  1  one-cycle pulse after the last writeback.
REQ-020 timeout_err  output  1  sticky flag: conv_done not seen within WAIT_MAX cycles.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, CLR, START, WAIT, WB.
REQ-022 IDLE: cmd_ready=1; on cmd_valid, latch the tile counts (a value of 0 is treated as 1), clear tile_row/tile_col to 0, and go to LOAD.
REQ-023 LOAD: load_req=1 is held until load_ack is sampled high, then go to CLR.
REQ-024 CLR: conv_clr=1 for exactly one cycle, then go to START.
REQ-025 START: conv_start=1 for exactly one cycle; clear the wait counter; go to WAIT.
REQ-026 WAIT: conv_done is ignored in the first WAIT cycle; conv_done high in any later cycle goes to WB.
REQ-027 WAIT timeout: if the wait counter reaches WAIT_MAX without conv_done, set timeout_err and go to WB anyway.
REQ-028 WB: wb_valid=1 is held until wb_valid&&wb_ready; tile_row/tile_col SHALL remain stable while wb_valid=1.
REQ-029 After the WB handshake, advance in raster order: col+1; at col=tiles_x-1, set col to 0 and row+1; then go to LOAD.
REQ-030 After the WB handshake of the tile at (tiles_y-1, tiles_x-1), pulse frame_done for one cycle and go to IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 cmd_valid outside IDLE SHALL be ignored; a command accepted in IDLE SHALL NOT be affected by later changes to cmd_tiles_x or cmd_tiles_y.
REQ-033 load_ack outside LOAD, and conv_done outside WAIT, SHALL be ignored.
REQ-034 Latency from the load_ack sample to the conv_start pulse SHALL be exactly 2 cycles (CLR, then START).
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 rst=1 SHALL force IDLE immediately (asynchronously), including mid-frame.
REQ-037 Reset values SHALL be: cmd_ready=1; tile_row=tile_col=0; counters 0; every other output 0, including timeout_err.
REQ-038 timeout_err SHALL be cleared only by rst.

Configuration
REQ-039 With macro CONV_SCHED_PERF_EN defined, the block SHALL add output perf_busy_cycles [15:0]: counts cycles with busy=1, saturates at 16'hFFFF, clears to 0 on rst and on each command acceptance.
REQ-040 Without CONV_SCHED_PERF_EN, the perf_busy_cycles port and its counter SHALL NOT exist.

Verification
REQ-041 Issue cmd 2x2 with load_ack, wb_ready and conv_done responding promptly -> exactly 4 conv_start pulses, wb tile order (0,0),(0,1),(1,0),(1,1), one frame_done.
REQ-042 Issue cmd 0x3 -> treated as 1x3: 3 tiles (0,0),(1,0),(2,0), then frame_done.
REQ-043 Hold conv_done=1 permanently -> every tile still passes CLR/START and WAIT; no tile is skipped; 1x1 frame completes in LOAD+5 cycles with wb_ready=1.
REQ-044 Hold conv_done=0 -> WB is entered WAIT_MAX cycles after START, timeout_err=1, and it stays set through the next frame.
REQ-045 Hold wb_ready=0 for 10 cycles -> wb_valid, tile_row and tile_col stay stable; advance occurs on the cycle wb_ready=1.
REQ-046 Assert rst during WAIT of tile (0,1) -> outputs return to reset values; the next command starts at (0,0).
